// File: rtl/hex_led_pkg.sv
// hex_led_pkg: shared types and constants for the hex LED display engine.
//   seg7_t      - 7-bit segment vector, bit order g..a
//   SEG_OFF_AL  - all-off segment pattern in active-low polarity
//   hex_seg_al  - nibble to active-low segment pattern lookup
package hex_led_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_OFF_AL = 7'h7F;

  // Active-low glyph table: a lit segment is 0, bit order g..a.
  function automatic seg7_t hex_seg_al(input logic [3:0] nib);
    seg7_t pat;
    case (nib)
      4'h0:    pat = 7'b1000000;
      4'h1:    pat = 7'b1111001;
      4'h2:    pat = 7'b0100100;
      4'h3:    pat = 7'b0110000;
      4'h4:    pat = 7'b0011001;
      4'h5:    pat = 7'b0010010;
      4'h6:    pat = 7'b0000010;
      4'h7:    pat = 7'b1011000;
      4'h8:    pat = 7'b0000000;
      4'h9:    pat = 7'b0010000;
      4'hA:    pat = 7'b0001000;
      4'hB:    pat = 7'b0000011;
      4'hC:    pat = 7'b1000110;
      4'hD:    pat = 7'b0100001;
      4'hE:    pat = 7'b0000110;
      4'hF:    pat = 7'b0001110;
      default: pat = SEG_OFF_AL;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/hex_led_scan_hex7_decode.sv
// hex7_decode: combinational nibble to 7-segment decoder with dark override.
// Ports:
//   nibble_i     - hex digit value
//   dark_i       - 1 forces the all-off pattern
//   active_low_i - 1: lit segment is 0; 0: lit segment is 1
//   seg_o        - segment pattern, bit order g..a
import hex_led_pkg::*;

module hex7_decode (
  input  logic [3:0] nibble_i,
  input  logic       dark_i,
  input  logic       active_low_i,
  output logic [6:0] seg_o
);

  seg7_t seg_al_s;

  // Look up the glyph in active-low form, then apply output polarity.
  always_comb begin
    if (dark_i) begin
      seg_al_s = SEG_OFF_AL;
    end else begin
      seg_al_s = hex_seg_al(nibble_i);
    end
    if (active_low_i) begin
      seg_o = seg_al_s;
    end else begin
      seg_o = ~seg_al_s;
    end
  end

endmodule

// File: rtl/hex_led_scan.sv
// hex_led_scan: parametrised 7-segment hex display engine.
// A load strobe captures the packed nibble value into a shadow register so
// the display never shows a half-updated value. Two registered output forms:
// a parallel per-digit segment bus and a time-multiplexed seg/dig_sel pair.
// Per-digit blanking and blinking are always present.
// Optional build macro HEX_LED_LZB_EN adds input lz_en for leading-zero
// suppression (digit 0 is never suppressed).
// Ports:
//   clk        - system clock
//   reset_n    - synchronous active-low reset
//   value      - packed nibbles, digit 0 = [3:0]
//   load       - capture value into the shadow register
//   blank_mask - 1 = digit always dark
//   blink_mask - 1 = digit dark during blink phase
//   lz_en      - (HEX_LED_LZB_EN only) enable leading-zero suppression
//   hex_par    - parallel segments, digit k = [7k+6:7k], bit order g..a
//   seg        - multiplexed segment bus, bit order g..a
//   dig_sel    - one-hot multiplexed digit enable
//   scan_idx   - digit currently shown on seg/dig_sel
import hex_led_pkg::*;

module hex_led_scan #(
  parameter int DIGITS          = 6,
  parameter int SCAN_DIV_WIDTH  = 16,
  parameter int BLINK_DIV_WIDTH = 24,
  parameter bit SEG_ACTIVE_LOW  = 1'b1,
  parameter bit DIG_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DIGITS*4-1:0]   value,
  input  logic                  load,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic [DIGITS-1:0]     blink_mask,
`ifdef HEX_LED_LZB_EN
  input  logic                  lz_en,
`endif
  output logic [DIGITS*7-1:0]   hex_par,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     dig_sel,
  output logic [2:0]            scan_idx
);

  localparam logic [6:0]        SEG_OFF  = SEG_ACTIVE_LOW ? SEG_OFF_AL : 7'h00;
  localparam logic [DIGITS-1:0] DIG_OFF  = DIG_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
  localparam logic [2:0]        LAST_IDX = 3'(DIGITS - 1);

  logic [DIGITS*4-1:0]         shadow_q;
  logic [SCAN_DIV_WIDTH-1:0]   presc_q;
  logic [BLINK_DIV_WIDTH-1:0]  blink_q;
  logic [2:0]                  scan_idx_q, scan_idx_d;
  logic [DIGITS*7-1:0]         hex_par_q, hex_par_d;
  logic [6:0]                  seg_q, seg_d;
  logic [DIGITS-1:0]           dig_sel_q, dig_sel_d;

  logic                        blink_phase_s;
  logic                        scan_adv_s;
  logic [DIGITS-1:0]           lz_dark_s;
  logic [DIGITS-1:0]           dark_s;
  logic [3:0]                  mux_nib_s;
  logic                        mux_dark_s;

  assign blink_phase_s = blink_q[BLINK_DIV_WIDTH-1];
  assign scan_adv_s    = (presc_q == {SCAN_DIV_WIDTH{1'b1}});

`ifdef HEX_LED_LZB_EN
  logic nz_seen_s;

  // Walk from the top digit down; digits stay dark until the first nonzero one.
  always_comb begin
    lz_dark_s = '0;
    nz_seen_s = 1'b0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      if (shadow_q[4*k +: 4] != 4'h0) begin
        nz_seen_s = 1'b1;
      end else begin
        nz_seen_s = nz_seen_s;
      end
      lz_dark_s[k] = lz_en & ~nz_seen_s;
    end
  end
`else
  assign lz_dark_s = '0;
`endif

  assign dark_s = blank_mask | (blink_mask & {DIGITS{blink_phase_s}}) | lz_dark_s;

  // One decoder per digit feeds the parallel bus.
  for (genvar g = 0; g < DIGITS; g++) begin : g_par_dec
    hex7_decode u_dec (
      .nibble_i     (shadow_q[4*g +: 4]),
      .dark_i       (dark_s[g]),
      .active_low_i (SEG_ACTIVE_LOW),
      .seg_o        (hex_par_d[7*g +: 7])
    );
  end

  // Pick the nibble and dark flag of the digit under scan.
  always_comb begin
    mux_nib_s  = 4'h0;
    mux_dark_s = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (scan_idx_q == 3'(k)) begin
        mux_nib_s  = shadow_q[4*k +: 4];
        mux_dark_s = dark_s[k];
      end else begin
        mux_nib_s  = mux_nib_s;
        mux_dark_s = mux_dark_s;
      end
    end
  end

  hex7_decode u_mux_dec (
    .nibble_i     (mux_nib_s),
    .dark_i       (mux_dark_s),
    .active_low_i (SEG_ACTIVE_LOW),
    .seg_o        (seg_d)
  );

  // One-hot digit select for the current scan index, in output polarity.
  always_comb begin
    dig_sel_d = '0;
    for (int k = 0; k < DIGITS; k++) begin
      dig_sel_d[k] = (scan_idx_q == 3'(k)) ^ DIG_ACTIVE_LOW;
    end
  end

  // Scan index steps on prescaler wrap and folds back after the last digit.
  always_comb begin
    if (!scan_adv_s) begin
      scan_idx_d = scan_idx_q;
    end else if (scan_idx_q == LAST_IDX) begin
      scan_idx_d = 3'd0;
    end else begin
      scan_idx_d = scan_idx_q + 3'd1;
    end
  end

  // State and registered outputs; reset wins over load.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shadow_q   <= '0;
      presc_q    <= '0;
      blink_q    <= '0;
      scan_idx_q <= 3'd0;
      hex_par_q  <= {DIGITS{SEG_OFF}};
      seg_q      <= SEG_OFF;
      dig_sel_q  <= DIG_OFF;
    end else begin
      if (load) begin
        shadow_q <= value;
      end else begin
        shadow_q <= shadow_q;
      end
      presc_q    <= presc_q + SCAN_DIV_WIDTH'(1);
      blink_q    <= blink_q + BLINK_DIV_WIDTH'(1);
      scan_idx_q <= scan_idx_d;
      hex_par_q  <= hex_par_d;
      seg_q      <= seg_d;
      dig_sel_q  <= dig_sel_d;
    end
  end

  assign hex_par  = hex_par_q;
  assign seg      = seg_q;
  assign dig_sel  = dig_sel_q;
  assign scan_idx = scan_idx_q;

endmodule

// File: tb/tb_hex_led_scan.sv
// tb_hex_led_scan: self-checking bench for hex_led_scan (DIGITS=6,
// SCAN_DIV_WIDTH=2, BLINK_DIV_WIDTH=4, active-low segments and digits).
// A cycle model pushes the expected registered outputs before each clock
// edge; they are popped and compared just after the edge.
module tb_hex_led_scan;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [23:0] value;
  logic        load;
  logic [5:0]  blank_mask;
  logic [5:0]  blink_mask;
  logic        lz_en;
  logic [41:0] hex_par;
  logic [6:0]  seg;
  logic [5:0]  dig_sel;
  logic [2:0]  scan_idx;

  always #5 clk = ~clk;

  hex_led_scan #(
    .DIGITS          (6),
    .SCAN_DIV_WIDTH  (2),
    .BLINK_DIV_WIDTH (4),
    .SEG_ACTIVE_LOW  (1'b1),
    .DIG_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .value      (value),
    .load       (load),
    .blank_mask (blank_mask),
    .blink_mask (blink_mask),
`ifdef HEX_LED_LZB_EN
    .lz_en      (lz_en),
`endif
    .hex_par    (hex_par),
    .seg        (seg),
    .dig_sel    (dig_sel),
    .scan_idx   (scan_idx)
  );

  typedef struct packed {
    logic [41:0] hp;
    logic [6:0]  sg;
    logic [5:0]  ds;
    logic [2:0]  si;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // reference model state
  logic [23:0] m_sh;
  logic [1:0]  m_pr;
  logic [3:0]  m_bl;
  logic [2:0]  m_ix;

  function automatic logic [6:0] ref_seg(input logic [3:0] n);
    logic [6:0] p;
    case (n)
      4'h0: p = 7'b1000000;  4'h1: p = 7'b1111001;
      4'h2: p = 7'b0100100;  4'h3: p = 7'b0110000;
      4'h4: p = 7'b0011001;  4'h5: p = 7'b0010010;
      4'h6: p = 7'b0000010;  4'h7: p = 7'b1011000;
      4'h8: p = 7'b0000000;  4'h9: p = 7'b0010000;
      4'hA: p = 7'b0001000;  4'hB: p = 7'b0000011;
      4'hC: p = 7'b1000110;  4'hD: p = 7'b0100001;
      4'hE: p = 7'b0000110;  4'hF: p = 7'b0001110;
      default: p = 7'h7F;
    endcase
    return p;
  endfunction

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: push model expectation, take the edge, pop and compare.
  task automatic tick();
    exp_t       e;
    logic [5:0] dk;
    logic       nz;
    if (!reset_n) begin
      e.hp = {6{7'h7F}};
      e.sg = 7'h7F;
      e.ds = 6'b111111;
      e.si = 3'd0;
    end else begin
      nz = 1'b0;
      for (int k = 0; k < 6; k++) dk[k] = blank_mask[k] | (blink_mask[k] & m_bl[3]);
`ifdef HEX_LED_LZB_EN
      for (int k = 5; k >= 1; k--) begin
        if (m_sh[4*k +: 4] != 4'h0) nz = 1'b1;
        if (lz_en && !nz) dk[k] = 1'b1;
      end
`endif
      for (int k = 0; k < 6; k++) e.hp[7*k +: 7] = dk[k] ? 7'h7F : ref_seg(m_sh[4*k +: 4]);
      e.sg = e.hp[7*m_ix +: 7];
      e.ds = ~(6'b000001 << m_ix);
      if (m_pr == 2'd3) e.si = (m_ix == 3'd5) ? 3'd0 : m_ix + 3'd1;
      else              e.si = m_ix;
    end
    exp_q.push_back(e);
    @(posedge clk);
    if (!reset_n) begin
      m_sh = 24'h0; m_pr = 2'd0; m_bl = 4'd0; m_ix = 3'd0;
    end else begin
      if (load) m_sh = value;
      m_ix = e.si;
      m_pr = m_pr + 2'd1;
      m_bl = m_bl + 4'd1;
    end
    #1;
    e = exp_q.pop_front();
    check_val("hex_par",  {22'h0, hex_par}, {22'h0, e.hp});
    check_val("seg",      {57'h0, seg},     {57'h0, e.sg});
    check_val("dig_sel",  {58'h0, dig_sel}, {58'h0, e.ds});
    check_val("scan_idx", {61'h0, scan_idx}, {61'h0, e.si});
  endtask

  initial begin
    reset_n = 1'b0; load = 1'b0; value = 24'h0;
    blank_mask = 6'b0; blink_mask = 6'b0; lz_en = 1'b0;
    m_sh = 24'h0; m_pr = 2'd0; m_bl = 4'd0; m_ix = 3'd0;

    // reset state
    repeat (3) tick();
    check_val("rst_hex_par",  {22'h0, hex_par},  {22'h0, {6{7'h7F}}});
    check_val("rst_seg",      {57'h0, seg},      64'h7F);
    check_val("rst_dig_sel",  {58'h0, dig_sel},  64'h3F);
    check_val("rst_scan_idx", {61'h0, scan_idx}, 64'h0);
    reset_n = 1'b1;
    repeat (2) tick();

    // load latency: old value after load edge, new one edge later
    value = 24'h0123AF; load = 1'b1;
    tick();
    load = 1'b0;
    check_val("ld_lat_d0_old", {57'h0, hex_par[6:0]}, {57'h0, 7'b1000000});
    tick();
    check_val("ld_d0", {57'h0, hex_par[6:0]},   {57'h0, 7'b0001110});
    check_val("ld_d1", {57'h0, hex_par[13:7]},  {57'h0, 7'b0001000});
    check_val("ld_d2", {57'h0, hex_par[20:14]}, {57'h0, 7'b0110000});
    check_val("ld_d4", {57'h0, hex_par[34:28]}, {57'h0, 7'b1111001});
    check_val("ld_d5", {57'h0, hex_par[41:35]}, {57'h0, 7'b1000000});

    // scan sweep over more than one full rotation
    repeat (30) tick();

    // blank digit1, blink digit0
    blank_mask = 6'b000010; blink_mask = 6'b000001;
    tick();
    repeat (40) begin
      tick();
      check_val("blank_d1", {57'h0, hex_par[13:7]}, 64'h7F);
    end
    blank_mask = 6'b0; blink_mask = 6'b0;
    repeat (2) tick();

    // load on the same edge as a scan advance
    for (int i = 0; i < 8 && m_pr != 2'd3; i++) tick();
    value = 24'hFEDCBA; load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    check_val("ld_adv_seg", {57'h0, seg}, {57'h0, ref_seg(value[4*m_ix +: 4])});
    repeat (10) tick();

    // mid-scan reset restarts at digit 0
    repeat (5) tick();
    reset_n = 1'b0;
    tick();
    check_val("midrst_idx", {61'h0, scan_idx}, 64'h0);
    reset_n = 1'b1;
    repeat (12) tick();

`ifdef HEX_LED_LZB_EN
    // leading-zero suppression
    lz_en = 1'b1; value = 24'h000040; load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    check_val("lz_40", {22'h0, hex_par},
              {22'h0, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'b0011001, 7'b1000000});
    repeat (8) tick();
    value = 24'h000000; load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    check_val("lz_zero", {22'h0, hex_par},
              {22'h0, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'b1000000});
    repeat (26) tick();
    lz_en = 1'b0;
    repeat (4) tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
